vscale_dmem_responder: RTL and testbench
========================================

// Module: vscale_dmem_responder
// PURPOSE
//  Data-memory responder for the vscale core's dmem port; the memory side of the interface the pipeline control drives.
//  Accepts load/store requests in the core's DX stage and completes them in the following (WB) cycle or later.
//  Stalls the core via dmem_wait and reports bad accesses via dmem_badmem_e. Word-organised on-chip RAM.
//  Used as the simulation and FPGA data memory behind the core.
// PARAMETERS
//  DEPTH_WORDS  1024        RAM depth in 32-bit words; must be a power of two.
//  BASE_ADDR    32'h0000_0000  byte address of word 0; must be aligned to DEPTH_WORDS*4.
//  WAIT_CYCLES  0           fixed wait states inserted before each response (0..15).
//  LFSR_SEED    16'hACE1    nonzero reset value of the wait-state LFSR (used only with the optional feature).
// PORTS
//  clk            in   1   clock
//  reset          in   1   synchronous, active-high reset
//  dmem_en        in   1   request valid (DX stage)
//  dmem_wen       in   1   1 = store, 0 = load; qualified by dmem_en
//  dmem_size      in   3   funct3 of the access; [1:0] 00 = byte, 01 = half, 10 = word, 11 = invalid; [2] ignored
//  dmem_addr      in   32  byte address, valid with dmem_en
//  dmem_wdata     in   32  store data, low-aligned; valid during the response cycle (WB)
//  dmem_rdata     out  32  full aligned word read; valid when response completes; core performs lane select and extension
//  dmem_wait      out  1   response not complete; core holds WB and DX stages stalled
//  dmem_badmem_e  out  1   completing access faulted; asserted only in the completion cycle
// BEHAVIOUR
//  Reset: state = IDLE; dmem_wait = 0; dmem_badmem_e = 0; dmem_rdata = 0; wait counter = 0; pending write dropped.
//    RAM contents are not cleared.
//  Acceptance: a request is accepted at a posedge where dmem_en = 1 and the block is in IDLE or completing a response (RESP).
//    The request is not accepted during WAIT. The core holds the request stable while dmem_wait = 1.
//    Accepted addr, wen and size[1:0] are latched.
//  FSM: IDLE -accept-> (wait count == 0 ? RESP : WAIT).
//    WAIT: dmem_wait = 1; counter decrements; counter == 1 -> RESP.
//    RESP: dmem_wait = 0 (completion cycle); accept -> next as above; otherwise IDLE.
//  Latency: WAIT_CYCLES = 0 gives completion in the cycle after acceptance with no wait.
//    Otherwise dmem_wait is high for exactly N cycles, then completes.
//  Back-to-back: a request in the RESP cycle is accepted with no bubble; sustained throughput is 1 access/cycle at N = 0.
//  Fault check at acceptance; the result is reported at completion:
//    size 11;
//    half with addr[0] != 0;
//    word with addr[1:0] != 0;
//    addr outside [BASE_ADDR, BASE_ADDR + DEPTH_WORDS*4).
//    A faulting access: no RAM write, dmem_rdata = 0, dmem_badmem_e = 1 for the completion cycle only.
//    It consumes the same wait states.
//  Load: RAM is read at the acceptance edge, word index = (addr - BASE_ADDR) >> 2.
//    The word is held in dmem_rdata from completion until the next load completes.
//  Store: dmem_wdata is sampled at the completion edge and shifted into lanes by addr[1:0].
//    Byte enables: byte = 1 lane; half = lanes {1:0} or {3:2}; word = all.
//    The write commits at that edge.
//  RAW forwarding: a load accepted at the same edge a store to the same word commits returns the merged word.
//    Merged = new bytes in enabled lanes, old RAM bytes elsewhere.
//  Index arithmetic uses log2(DEPTH_WORDS) bits after the range check; addresses never wrap into the RAM.
//  dmem_en = 0 in IDLE: no state change. Reset asserted in WAIT/RESP aborts the access; no write occurs.
// CONFIGURATION
//  VSCALE_DMEM_RAND_WAIT_EN defined: a 16-bit Galois LFSR (taps 16,14,13,11) advances once per accepted request.
//    Wait count = WAIT_CYCLES + lfsr[1:0], i.e. 0..3 extra cycles, reproducible from LFSR_SEED.
//    LFSR resets to LFSR_SEED.
//  Undefined: wait count = WAIT_CYCLES for every access; no LFSR logic present.
// TESTING
//  WAIT_CYCLES = 0:
//    SW 0xDEADBEEF at 0x10, then LW 0x10 back-to-back -> dmem_wait never high; LW rdata = 0xDEADBEEF (forwarded).
//    SB 0xAA at 0x13 over word 0x11223344 -> LW 0x10 returns 0xAA223344.
//    SH 0x5566 at 0x12 -> 0x55663344.
//  WAIT_CYCLES = 3: LW -> dmem_wait high exactly 3 cycles, data on the 4th post-accept cycle.
//    A request held during the wait is not re-accepted.
//  Faults: LW 0x11, LH 0x13, size 3'b011, SW BASE_ADDR + DEPTH_WORDS*4 -> each gives badmem_e = 1 for one cycle.
//    rdata = 0 and the RAM is unchanged (verified by readback).
//  Reset in a WAIT cycle of a pending SW 0x20 -> next cycle dmem_wait = 0, state IDLE.
//    LW 0x20 returns the pre-store value.
//  With VSCALE_DMEM_RAND_WAIT_EN: 64 LW/SW pairs to random valid addresses.
//    Wait lengths match a reference LFSR from 16'hACE1; readback matches the scoreboard.

Source files
------------

// File: rtl/vscale_dmem_responder.sv
// rtl/vscale_dmem_responder.sv - word-organised data memory behind the vscale dmem port
// Optional random wait states: define VSCALE_DMEM_RAND_WAIT_EN.
module vscale_dmem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dmem_en,
  input  logic        dmem_wen,
  input  logic [2:0]  dmem_size,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_wait,
  output logic        dmem_badmem_e
);

  localparam int          AW   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [1:0]    state;
  logic [4:0]    wait_cnt;
  logic [4:0]    acc_wait;
  logic          req_wen;
  logic          req_fault;
  logic [1:0]    req_size;
  logic [1:0]    req_lane;
  logic [AW-1:0] req_idx;
  logic [31:0]   rd_pend;
  logic [31:0]   rd_hold;

  logic          accept;
  logic [31:0]   offset;
  logic          in_range;
  logic          misalign;
  logic          acc_fault;
  logic [AW-1:0] acc_idx;
  logic          commit;
  logic [3:0]    be;
  logic [31:0]   wdata_sh;
  logic [31:0]   merged;
  logic [31:0]   rd_word;
  logic          unused_bits;

  assign accept   = dmem_en && (state == S_IDLE || state == S_RESP);
  assign offset   = dmem_addr - BASE_ADDR;
  // Subtraction wraps addresses below the base to large offsets, so one compare covers both ends.
  assign in_range = {1'b0, offset} < SPAN;
  assign misalign = (dmem_size[1:0] == 2'b11) ||
                    (dmem_size[1:0] == 2'b01 && dmem_addr[0]) ||
                    (dmem_size[1:0] == 2'b10 && dmem_addr[1:0] != 2'b00);
  assign acc_fault = !in_range || misalign;
  assign acc_idx   = offset[AW+1:2];

  assign commit   = (state == S_RESP) && req_wen && !req_fault;
  assign wdata_sh = dmem_wdata << {req_lane, 3'b000};

  always_comb begin
    be = 4'b0000;
    case (req_size)
      2'b00:   be[req_lane] = 1'b1;
      2'b01:   be = req_lane[1] ? 4'b1100 : 4'b0011;
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  always_comb begin
    merged = mem[req_idx];
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = wdata_sh[8*i +: 8];
    end
  end

  // A load accepted on the edge that commits a store to the same word sees the new bytes.
  assign rd_word = (commit && acc_idx == req_idx) ? merged : mem[acc_idx];

`ifdef VSCALE_DMEM_RAND_WAIT_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk) begin
    if (reset) lfsr <= LFSR_SEED;
    else if (accept) lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  end

  assign acc_wait = 5'(WAIT_CYCLES) + {3'b000, lfsr[1:0]};
`else
  assign acc_wait = 5'(WAIT_CYCLES);
`endif

  assign unused_bits = ^{dmem_size[2], LFSR_SEED};

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      wait_cnt  <= 5'd0;
      req_wen   <= 1'b0;
      req_fault <= 1'b0;
      req_size  <= 2'b00;
      req_lane  <= 2'b00;
      req_idx   <= '0;
      rd_pend   <= 32'h0;
      rd_hold   <= 32'h0;
    end else begin
      if (state == S_RESP && !req_wen) rd_hold <= req_fault ? 32'h0 : rd_pend;
      case (state)
        S_IDLE, S_RESP: begin
          if (accept) begin
            req_wen   <= dmem_wen;
            req_fault <= acc_fault;
            req_size  <= dmem_size[1:0];
            req_lane  <= dmem_addr[1:0];
            req_idx   <= acc_idx;
            rd_pend   <= rd_word;
            wait_cnt  <= acc_wait;
            state     <= (acc_wait == 5'd0) ? S_RESP : S_WAIT;
          end else begin
            state <= S_IDLE;
          end
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt - 5'd1;
          if (wait_cnt == 5'd1) state <= S_RESP;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && commit) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[req_idx][8*i +: 8] <= wdata_sh[8*i +: 8];
      end
    end
  end

  assign dmem_wait     = (state == S_WAIT);
  assign dmem_badmem_e = (state == S_RESP) && req_fault;
  assign dmem_rdata    = (state != S_RESP) ? rd_hold :
                         req_fault         ? 32'h0   :
                         req_wen           ? rd_hold : rd_pend;

endmodule

// File: tb/tb_vscale_dmem_responder.sv
// tb/tb_vscale_dmem_responder.sv - randomized scoreboard bench, instances at 0 and 3 wait states
module tb_vscale_dmem_responder;

  localparam int     DEPTH = 64;
  localparam longint BASE  = 0;
  localparam longint SPAN  = DEPTH * 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        en    [2];
  logic        wen   [2];
  logic [2:0]  size  [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic        wt    [2];
  logic        bad   [2];

  logic [31:0] mdl  [2][DEPTH];
  logic [15:0] lfsr_ref [2];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  vscale_dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0), .WAIT_CYCLES(0), .LFSR_SEED(16'hACE1)) dut0 (
    .clk(clk), .reset(reset), .dmem_en(en[0]), .dmem_wen(wen[0]), .dmem_size(size[0]),
    .dmem_addr(addr[0]), .dmem_wdata(wdata[0]), .dmem_rdata(rdata[0]),
    .dmem_wait(wt[0]), .dmem_badmem_e(bad[0]));

  vscale_dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0), .WAIT_CYCLES(3), .LFSR_SEED(16'hACE1)) dut1 (
    .clk(clk), .reset(reset), .dmem_en(en[1]), .dmem_wen(wen[1]), .dmem_size(size[1]),
    .dmem_addr(addr[1]), .dmem_wdata(wdata[1]), .dmem_rdata(rdata[1]),
    .dmem_wait(wt[1]), .dmem_badmem_e(bad[1]));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit is_fault(input logic [2:0] sz, input logic [31:0] a);
    longint la;
    la = longint'(a);
    return (sz[1:0] == 2'b11) || (sz[1:0] == 2'b01 && a[0]) ||
           (sz[1:0] == 2'b10 && a[1:0] != 2'b00) || la < BASE || la >= BASE + SPAN;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Called at a negedge while the target is idle or in its completion cycle; returns in the completion cycle.
  task automatic access(input int d, input bit w, input logic [2:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input string tag);
    int ew;
    int cnt;
    bit f;
    logic [31:0] ed;
    int idx;
    f   = is_fault(sz, a);
    idx = int'(a[7:2]);
    ew  = (d == 1) ? 3 : 0;
`ifdef VSCALE_DMEM_RAND_WAIT_EN
    ew = ew + int'(lfsr_ref[d][1:0]);
    lfsr_ref[d] = lfsr_next(lfsr_ref[d]);
`endif
    ed = f ? 32'h0 : mdl[d][idx];
    en[d] = 1'b1; wen[d] = w; size[d] = sz; addr[d] = a;
    @(negedge clk);
    cnt = 0;
    while (wt[d] === 1'b1 && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    en[d] = 1'b0;
    wdata[d] = wd;
    check_val({tag, ".wait"}, 32'(cnt), 32'(ew));
    check_val({tag, ".bad"}, {31'b0, bad[d]}, {31'b0, f});
    if (!w || f) check_val({tag, ".rdata"}, rdata[d], ed);
    if (w && !f) begin
      case (sz[1:0])
        2'b00:   mdl[d][idx][8*a[1:0] +: 8] = wd[7:0];
        2'b01:   mdl[d][idx][16*a[1] +: 16] = wd[15:0];
        default: mdl[d][idx] = wd;
      endcase
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int d;
    int sz;
    logic [31:0] a;
    for (int i = 0; i < 2; i++) begin
      en[i] = 1'b0; wen[i] = 1'b0; size[i] = 3'b010; addr[i] = 32'h0; wdata[i] = 32'h0;
      lfsr_ref[i] = 16'hACE1;
    end
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check_val("reset.wait", {31'b0, wt[i]}, 32'h0);
      check_val("reset.bad", {31'b0, bad[i]}, 32'h0);
      check_val("reset.rdata", rdata[i], 32'h0);
    end

    for (int i = 0; i < 2; i++)
      for (int j = 0; j < DEPTH; j++) access(i, 1'b1, 3'b010, 32'(j * 4), $urandom, "init");

    access(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, "sw_fwd");
    access(0, 1'b0, 3'b010, 32'h10, 32'h0, "lw_fwd");
    check_val("fwd_const", rdata[0], 32'hDEADBEEF);
    access(0, 1'b1, 3'b010, 32'h10, 32'h11223344, "sw_base");
    access(0, 1'b1, 3'b000, 32'h13, 32'h000000AA, "sb");
    access(0, 1'b0, 3'b010, 32'h10, 32'h0, "lw_sb");
    check_val("sb_const", rdata[0], 32'hAA223344);
    access(0, 1'b1, 3'b010, 32'h10, 32'h11223344, "sw_base2");
    access(0, 1'b1, 3'b001, 32'h12, 32'h00005566, "sh");
    access(0, 1'b0, 3'b010, 32'h10, 32'h0, "lw_sh");
    check_val("sh_const", rdata[0], 32'h55663344);
    idle(1);
    check_val("hold_rdata", rdata[0], 32'h55663344);

    access(1, 1'b0, 3'b010, 32'h10, 32'h0, "lw_wait3");
    idle(1);
    check_val("wait3_idle", {31'b0, wt[1]}, 32'h0);

    for (int i = 0; i < 2; i++) begin
      access(i, 1'b0, 3'b010, 32'h11, 32'h0, "f_lw11");
      access(i, 1'b0, 3'b001, 32'h13, 32'h0, "f_lh13");
      access(i, 1'b0, 3'b011, 32'h14, 32'h0, "f_size3");
      access(i, 1'b1, 3'b010, 32'(SPAN), 32'hFFFF0000, "f_sw_oob");
      idle(1);
      check_val("f_one_cycle", {31'b0, bad[i]}, 32'h0);
      access(i, 1'b0, 3'b010, 32'h00, 32'h0, "rb_w0");
      access(i, 1'b0, 3'b010, 32'h10, 32'h0, "rb_w10");
      access(i, 1'b0, 3'b010, 32'h14, 32'h0, "rb_w14");
    end

    idle(1);
    en[1] = 1'b1; wen[1] = 1'b1; size[1] = 3'b010; addr[1] = 32'h20;
`ifdef VSCALE_DMEM_RAND_WAIT_EN
    lfsr_ref[1] = lfsr_next(lfsr_ref[1]);
`endif
    idle(1);
    check_val("rst_in_wait", {31'b0, wt[1]}, 32'h1);
    reset = 1'b1;
    en[1] = 1'b0;
    idle(1);
    reset = 1'b0;
    lfsr_ref[0] = 16'hACE1;
    lfsr_ref[1] = 16'hACE1;
    check_val("rst_abort.wait", {31'b0, wt[1]}, 32'h0);
    check_val("rst_abort.bad", {31'b0, bad[1]}, 32'h0);
    access(1, 1'b0, 3'b010, 32'h20, 32'h0, "rst_lw20");

    for (int k = 0; k < 64; k++) begin
      d  = int'($urandom_range(0, 1));
      sz = int'($urandom_range(0, 2));
      a  = 32'($urandom_range(0, DEPTH - 1) * 4);
      if (sz == 0) a = a + 32'($urandom_range(0, 3));
      if (sz == 1) a = a + 32'($urandom_range(0, 1) * 2);
      if ($urandom_range(0, 3) == 0) begin
        sz = int'($urandom_range(0, 3));
        a  = 32'($urandom_range(0, 32'(SPAN) + 63));
      end
      access(d, 1'b1, 3'(sz), a, $urandom, "rnd_st");
      access(d, 1'b0, 3'b010, {a[31:2], 2'b00}, 32'h0, "rnd_ld");
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 2)));
    end

    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
